// File: rtl/shift_left_logical_32bit_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_left_logical_32bit_seq_if                                 |
// | Purpose  : Handshake/data bundle for the sequential 32-bit left shifter.   |
// |            The master requests a shift; the slave (the shifter) answers.   |
// | Signals  : start - request pulse, sampled by the slave only when idle      |
// |            X     - 32-bit operand, captured on an accepted start           |
// |            Y     - 32-bit unsigned shift amount, captured with X           |
// |            busy  - shift in progress                                       |
// |            done  - one-cycle completion pulse                              |
// |            Z     - registered result, held until the next completion      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface shift_left_logical_32bit_seq_if;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] Z;

  modport master (
    output start, X, Y,
    input  busy, done, Z
  );

  modport slave (
    input  start, X, Y,
    output busy, done, Z
  );
endinterface
`default_nettype wire

// File: rtl/shift_left_logical_32bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_left_logical_32bit_seq                                    |
// | Purpose  : Multi-cycle 32-bit logical left shifter, Z = X << Y, zero fill. |
// |            Five logarithmic stages (shift by 1,2,4,8,16), one per clock.   |
// |            Y >= 32 yields 0 (Y is unsigned).                               |
// | Ports    : clk   - rising-edge clock                                       |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - slave modport: start/X/Y in, busy/done/Z out            |
// | Config   : SLL_EARLY_DONE_EN - when defined, a captured Y of 0 or >= 32    |
// |            completes one edge after acceptance instead of five.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_left_logical_32bit_seq (
  input  logic                                clk,
  input  logic                                rst_n,
  shift_left_logical_32bit_seq_if.slave       bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] work,  work_n;
  logic [31:0] amt,   amt_n;
  logic [2:0]  k,     k_n;
  logic [31:0] z_q,   z_n;
  logic        done_q, done_n;

  logic [31:0] stage_out;
  logic        big_amt;

  // Any set bit above bit 4 means a shift of 32 or more: everything falls off.
  assign big_amt = |amt[31:5];

  // One logarithmic stage: shift by 2^k when the matching amount bit is set.
  always_comb begin
    stage_out = work;
    if (amt[{2'b00, k}]) begin
      case (k)
        3'd0:    stage_out = work << 1;
        3'd1:    stage_out = work << 2;
        3'd2:    stage_out = work << 4;
        3'd3:    stage_out = work << 8;
        3'd4:    stage_out = work << 16;
        default: stage_out = work;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= 32'h0;
      amt    <= 32'h0;
      k      <= 3'd0;
      z_q    <= 32'h0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      amt    <= amt_n;
      k      <= k_n;
      z_q    <= z_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    work_n  = work;
    amt_n   = amt;
    k_n     = k;
    z_n     = z_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // Also reached in the done cycle, so back-to-back starts are accepted.
        if (bus.start) begin
          work_n  = bus.X;
          amt_n   = bus.Y;
          k_n     = 3'd0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        work_n = stage_out;
        k_n    = k + 3'd1;
`ifdef SLL_EARLY_DONE_EN
        // Trivial amounts finish on the first stage edge with stages skipped.
        if ((k == 3'd0) && ((amt == 32'h0) || big_amt)) begin
          z_n     = big_amt ? 32'h0 : work;
          done_n  = 1'b1;
          state_n = IDLE;
        end else
`endif
        if (k == 3'd4) begin
          z_n     = big_amt ? 32'h0 : stage_out;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.Z    = z_q;

endmodule
`default_nettype wire
